// File: rtl/ks_adder_arbiter.sv
// Round-robin arbiter that lets two requesters share one external W-bit adder.
// It registers the winner's operands, holds them for ADD_LAT cycles, captures the sum, and returns it on a valid/ready port.
//
//   state  | meaning
//   IDLE   | no operation in flight; the next request is granted at the edge
//   SETTLE | adder inputs held; counting down the adder settle time
//   RESP   | result captured; valid held until the consumer takes it
module ks_adder_arbiter #(
  parameter int W       = 28,
  parameter int ADD_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [W-1:0] x0,
  input  logic [W-1:0] y0,
  input  logic         cin0,
  output logic         gnt0,
  input  logic         req1,
  input  logic [W-1:0] x1,
  input  logic [W-1:0] y1,
  input  logic         cin1,
  output logic         gnt1,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  output logic         add_cin,
  input  logic [W-1:0] add_sum,
  input  logic         add_cout,
  output logic         valid,
  output logic         id,
  output logic [W-1:0] sum,
  output logic         cout,
  input  logic         ready,
  output logic         busy
);

  localparam int CW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  state_t        state, state_nxt;
  logic          last;
  logic [CW-1:0] cnt;
  logic          load, win, capture, done;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    win       = 1'b0;
    capture   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (req0 | req1) begin
          load      = 1'b1;
          // On a tie, the requester that did not win last time goes next.
          win       = (req0 & req1) ? ~last : req1;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (ready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      last    <= 1'b1;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      add_a   <= '0;
      add_b   <= '0;
      add_cin <= 1'b0;
      cnt     <= '0;
      valid   <= 1'b0;
      id      <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      state <= state_nxt;
      gnt0  <= load & ~win;
      gnt1  <= load & win;
      if (load) begin
        add_a   <= win ? x1 : x0;
        add_b   <= win ? y1 : y0;
        add_cin <= win ? cin1 : cin0;
        id      <= win;
        last    <= win;
        cnt     <= CW'(ADD_LAT - 1);
      end else if (state == SETTLE && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (capture) begin
        sum   <= add_sum;
        cout  <= add_cout;
        valid <= 1'b1;
      end
      if (done) begin
        valid   <= 1'b0;
        add_a   <= '0;
        add_b   <= '0;
        add_cin <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
